fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, IF/ID pipeline register, error flags
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        branch_taken_E,
    input  logic [31:0] branch_target_E,
    input  logic [31:0] instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_plus4_F,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_plus4_D,
    output logic        valid_D,
    output logic        misalign_err,
    output logic        oob_err,
    output logic [15:0] fetch_cnt
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
    logic        valid_d_q, valid_d_d;
    logic        misalign_q, misalign_d;
    logic        oob_q, oob_d;
    logic [15:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic        load_d;
    logic        pc_oob;

    assign pc_plus4 = pc_f_q + 32'd4;
    assign load_d   = !flush_D && !stall_D;
    assign pc_oob   = ({2'b00, pc_f_q[31:2]} >= IMEM_LIMIT);

    // Next PC: redirect beats stall, stall beats sequential advance
    always_comb begin
        pc_f_d = pc_plus4;
        if (branch_taken_E) begin
            pc_f_d = {branch_target_E[31:2], 2'b00};
        end else if (stall_F) begin
            pc_f_d = pc_f_q;
        end
    end

    // IF/ID register: flush to a bubble beats stall, otherwise capture the fetch
    always_comb begin
        instr_d_d    = instr_d_q;
        pc_d_d       = pc_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        if (flush_D) begin
            instr_d_d    = 32'd0;
            pc_d_d       = 32'd0;
            pc_plus4_d_d = 32'd0;
            valid_d_d    = 1'b0;
        end else if (!stall_D) begin
            instr_d_d    = instr_F;
            pc_d_d       = pc_f_q;
            pc_plus4_d_d = pc_plus4;
            valid_d_d    = 1'b1;
        end
    end

    // Sticky error flags and saturating count of loads into IF/ID
    always_comb begin
        misalign_d = misalign_q;
        oob_d      = oob_q;
        cnt_d      = cnt_q;
        if (branch_taken_E && (branch_target_E[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
        if (load_d) begin
            if (pc_oob) begin
                oob_d = 1'b1;
            end
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // State registers; reset discards any pending redirect or stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f_q       <= RESET_PC;
            instr_d_q    <= 32'd0;
            pc_d_q       <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
            misalign_q   <= 1'b0;
            oob_q        <= 1'b0;
            cnt_q        <= 16'd0;
        end else begin
            pc_f_q       <= pc_f_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
            misalign_q   <= misalign_d;
            oob_q        <= oob_d;
            cnt_q        <= cnt_d;
        end
    end

    assign PC_F         = pc_f_q;
    assign PC_plus4_F   = pc_plus4;
    assign instr_D      = instr_d_q;
    assign PC_D         = pc_d_q;
    assign PC_plus4_D   = pc_plus4_d_q;
    assign valid_D      = valid_d_q;
    assign misalign_err = misalign_q;
    assign oob_err      = oob_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_F = 1'b0;
    logic        stall_D = 1'b0;
    logic        flush_D = 1'b0;
    logic        branch_taken_E = 1'b0;
    logic [31:0] branch_target_E = 32'd0;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [31:0] PC_plus4_F;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC_plus4_D;
    logic        valid_D;
    logic        misalign_err;
    logic        oob_err;
    logic [15:0] fetch_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Instruction memory stand-in: each word encodes its own address
    assign instr_F = 32'hA500_0000 ^ PC_F;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .flush_D         (flush_D),
        .branch_taken_E  (branch_taken_E),
        .branch_target_E (branch_target_E),
        .instr_F         (instr_F),
        .PC_F            (PC_F),
        .PC_plus4_F      (PC_plus4_F),
        .instr_D         (instr_D),
        .PC_D            (PC_D),
        .PC_plus4_D      (PC_plus4_D),
        .valid_D         (valid_D),
        .misalign_err    (misalign_err),
        .oob_err         (oob_err),
        .fetch_cnt       (fetch_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall_F = 0; stall_D = 0; flush_D = 0;
        branch_taken_E = 0; branch_target_E = 32'd0;
        rst = 0;
        #2;
        rst = 1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if (PC_F !== 32'd0 || PC_plus4_F !== 32'd4) begin
            $display("FAIL reset_pc: PC_F=%h PC_plus4_F=%h required 00000000/00000004", PC_F, PC_plus4_F);
            tests_failed++;
        end
        tests_run++;
        if (instr_D !== 32'd0 || PC_D !== 32'd0 || PC_plus4_D !== 32'd0 || valid_D !== 1'b0) begin
            $display("FAIL reset_ifid: instr_D=%h PC_D=%h PC_plus4_D=%h valid_D=%b required zeros", instr_D, PC_D, PC_plus4_D, valid_D);
            tests_failed++;
        end
        tests_run++;
        if (misalign_err !== 1'b0 || oob_err !== 1'b0 || fetch_cnt !== 16'd0) begin
            $display("FAIL reset_flags: misalign=%b oob=%b cnt=%0d required 0/0/0", misalign_err, oob_err, fetch_cnt);
            tests_failed++;
        end
        rst = 1;
        step();
    endtask

    task automatic test_sequential();
        logic [31:0] k4;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            k4 = 32'(4 * k);
            tests_run++;
            if (PC_F !== k4 || PC_D !== k4 - 32'd4 || PC_plus4_D !== k4 ||
                instr_D !== (32'hA500_0000 ^ (k4 - 32'd4)) || valid_D !== 1'b1 || fetch_cnt !== 16'(k)) begin
                $display("FAIL seq_edge%0d: PC_F=%h PC_D=%h PC_plus4_D=%h instr_D=%h valid=%b cnt=%0d required PC_F=%h PC_D=%h cnt=%0d",
                         k, PC_F, PC_D, PC_plus4_D, instr_D, valid_D, fetch_cnt, k4, k4 - 32'd4, k);
                tests_failed++;
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall_F = 1; stall_D = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (PC_F !== 32'h8 || PC_D !== 32'h4 || instr_D !== 32'hA500_0004 || valid_D !== 1'b1 || fetch_cnt !== 16'd2) begin
                $display("FAIL stall_hold%0d: PC_F=%h PC_D=%h instr_D=%h valid=%b cnt=%0d required 8/4/a5000004/1/2",
                         k, PC_F, PC_D, instr_D, valid_D, fetch_cnt);
                tests_failed++;
            end
        end
        stall_F = 0; stall_D = 0;
        step();
        tests_run++;
        if (PC_F !== 32'hC || PC_D !== 32'h8 || fetch_cnt !== 16'd3) begin
            $display("FAIL stall_release: PC_F=%h PC_D=%h cnt=%0d required c/8/3", PC_F, PC_D, fetch_cnt);
            tests_failed++;
        end
    endtask

    task automatic test_branch_flush();
        branch_taken_E = 1; branch_target_E = 32'h14; stall_F = 1; flush_D = 1;
        step();
        branch_taken_E = 0; stall_F = 0; flush_D = 0;
        tests_run++;
        if (PC_F !== 32'h14 || valid_D !== 1'b0 || instr_D !== 32'd0 || PC_D !== 32'd0 ||
            PC_plus4_D !== 32'd0 || fetch_cnt !== 16'd3 || misalign_err !== 1'b0) begin
            $display("FAIL branch_flush: PC_F=%h valid=%b instr_D=%h PC_D=%h PC_plus4_D=%h cnt=%0d mis=%b required 14/0/0/0/0/3/0",
                     PC_F, valid_D, instr_D, PC_D, PC_plus4_D, fetch_cnt, misalign_err);
            tests_failed++;
        end
        step();
        tests_run++;
        if (PC_F !== 32'h18 || PC_D !== 32'h14 || instr_D !== 32'hA500_0014 || valid_D !== 1'b1 || fetch_cnt !== 16'd4) begin
            $display("FAIL branch_target_fetch: PC_F=%h PC_D=%h instr_D=%h valid=%b cnt=%0d required 18/14/a5000014/1/4",
                     PC_F, PC_D, instr_D, valid_D, fetch_cnt);
            tests_failed++;
        end
    endtask

    task automatic test_misalign();
        branch_taken_E = 1; branch_target_E = 32'h16;
        step();
        branch_taken_E = 0;
        tests_run++;
        if (PC_F !== 32'h14 || misalign_err !== 1'b1) begin
            $display("FAIL misalign_set: PC_F=%h misalign=%b required 14/1", PC_F, misalign_err);
            tests_failed++;
        end
        tests_run++;
        if (PC_D !== 32'h18 || valid_D !== 1'b1 || fetch_cnt !== 16'd5) begin
            $display("FAIL branch_no_flush: PC_D=%h valid=%b cnt=%0d required 18/1/5", PC_D, valid_D, fetch_cnt);
            tests_failed++;
        end
        step();
        step();
        tests_run++;
        if (misalign_err !== 1'b1 || PC_F !== 32'h1C) begin
            $display("FAIL misalign_sticky: misalign=%b PC_F=%h required 1/1c", misalign_err, PC_F);
            tests_failed++;
        end
        do_reset();
        #1;
        tests_run++;
        if (misalign_err !== 1'b0) begin
            $display("FAIL misalign_clear: misalign=%b required 0", misalign_err);
            tests_failed++;
        end
    endtask

    task automatic test_oob_wrap();
        step();
        branch_taken_E = 1; branch_target_E = 32'h40;
        step();
        branch_taken_E = 0;
        step();
        tests_run++;
        if (PC_D !== 32'h40 || oob_err !== 1'b0 || PC_F !== 32'h44) begin
            $display("FAIL oob_last_word: PC_D=%h oob=%b PC_F=%h required 40/0/44", PC_D, oob_err, PC_F);
            tests_failed++;
        end
        step();
        tests_run++;
        if (PC_D !== 32'h44 || instr_D !== 32'hA500_0044 || oob_err !== 1'b1) begin
            $display("FAIL oob_set: PC_D=%h instr_D=%h oob=%b required 44/a5000044/1", PC_D, instr_D, oob_err);
            tests_failed++;
        end
        branch_taken_E = 1; branch_target_E = 32'hFFFF_FFFC;
        step();
        branch_taken_E = 0;
        tests_run++;
        if (PC_F !== 32'hFFFF_FFFC || PC_plus4_F !== 32'd0) begin
            $display("FAIL wrap_plus4: PC_F=%h PC_plus4_F=%h required fffffffc/00000000", PC_F, PC_plus4_F);
            tests_failed++;
        end
        step();
        tests_run++;
        if (PC_F !== 32'd0 || misalign_err !== 1'b0 || oob_err !== 1'b1) begin
            $display("FAIL wrap_pc: PC_F=%h misalign=%b oob=%b required 0/0/1", PC_F, misalign_err, oob_err);
            tests_failed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 8; k++) step();
        tests_run++;
        if (PC_F !== 32'h20 || fetch_cnt !== 16'd8) begin
            $display("FAIL pre_async: PC_F=%h cnt=%0d required 20/8", PC_F, fetch_cnt);
            tests_failed++;
        end
        branch_taken_E = 1; branch_target_E = 32'h32; stall_F = 1;
        #2;
        rst = 0;
        #1;
        tests_run++;
        if (PC_F !== 32'd0 || PC_plus4_F !== 32'd4 || instr_D !== 32'd0 || PC_D !== 32'd0 ||
            PC_plus4_D !== 32'd0 || valid_D !== 1'b0 || misalign_err !== 1'b0 || oob_err !== 1'b0 || fetch_cnt !== 16'd0) begin
            $display("FAIL async_reset: PC_F=%h PC_plus4_F=%h instr_D=%h PC_D=%h valid=%b mis=%b oob=%b cnt=%0d required reset values",
                     PC_F, PC_plus4_F, instr_D, PC_D, valid_D, misalign_err, oob_err, fetch_cnt);
            tests_failed++;
        end
        branch_taken_E = 0; branch_target_E = 32'd0; stall_F = 0;
        #1;
        rst = 1;
        step();
        tests_run++;
        if (PC_D !== 32'd0 || instr_D !== 32'hA500_0000 || valid_D !== 1'b1 || fetch_cnt !== 16'd1 || PC_F !== 32'h4) begin
            $display("FAIL post_reset_fetch: PC_D=%h instr_D=%h valid=%b cnt=%0d PC_F=%h required 0/a5000000/1/1/4",
                     PC_D, instr_D, valid_D, fetch_cnt, PC_F);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_flush();
        test_misalign();
        test_oob_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
